// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage in front of decode. Owns the fetch PC and issues
// one word read at a time to instruction memory over a req/ack handshake.
// Returned words and their PCs go into a small prefetch queue, which feeds
// decode over valid/ready. A branch redirect flushes the queue and re-steers
// the fetch PC.
//
// Ports
//   clk          clock, all state updates on posedge
//   reset        synchronous, active-high
//   redirect     taken branch: flush queue, refetch from redirect_pc
//   redirect_pc  new fetch address; bits [1:0] are forced to zero
//   mem_req      read request to instruction memory (registered)
//   mem_addr     word address of the request (registered)
//   mem_ack      one-cycle strobe, mem_data valid for the current request
//   mem_data     returned instruction word
//   inst_valid   queue head valid
//   inst         queue head instruction, 0 when !inst_valid
//   inst_pc      PC of queue head, 0 when !inst_valid
//   inst_ready   decode accepts the head this cycle
//   fsm_state    debug view of the fetch FSM (0 = RUN, 1 = DISCARD)
//
// Handshakes
//   Memory side: mem_req rises with mem_addr and then holds both unchanged
//   until the cycle mem_ack is high; that cycle completes the request (ack
//   may come in the very first cycle of mem_req). mem_ack while mem_req is
//   low is ignored. Decode side: a transfer happens on every posedge where
//   inst_valid && inst_ready; inst/inst_pc are zero whenever inst_valid is 0.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_data,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready,
  output logic [0:0]       fsm_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [0:0]       state;
  logic [WIDTH-1:0] fetch_pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] q_pc   [DEPTH];
  logic [WIDTH-1:0] q_data [DEPTH];

  // -------------------------------------------------------------------------
  // Next-state signals
  // -------------------------------------------------------------------------
  logic             ack_fire;
  logic             push;
  logic             pop;
  logic             outstanding_next;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] count_next;
  logic [WIDTH-1:0] fetch_pc_next;
  logic             req_next;
  logic [WIDTH-1:0] addr_next;
  logic [WIDTH-1:0] redirect_target;

  // The low two bits of a redirect target never reach any register.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign redirect_target = {redirect_pc[WIDTH-1:2], 2'b00};

  // An ack only counts against a live request.
  assign ack_fire = mem_req && mem_ack;

  // A redirect in the same cycle wins over both queue operations: the acked
  // word belongs to the wrong path and the head being popped is flushed.
  assign push = ack_fire && (state == ST_RUN) && !redirect;
  assign pop  = inst_valid && inst_ready && !redirect;

  // Request still in flight after this edge.
  assign outstanding_next = mem_req && !mem_ack;

  always_comb begin
    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        // A wrong-path request that cannot complete this cycle must still be
        // drained from memory before a new one can be issued.
        if (redirect && outstanding_next) state_next = ST_DISCARD;
        else                              state_next = ST_RUN;
      end
      ST_DISCARD: begin
        // Redirects here only move fetch_pc; the stale ack ends the drain.
        if (ack_fire) state_next = ST_RUN;
        else          state_next = ST_DISCARD;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect)  fetch_pc_next = redirect_target;
    else if (push) fetch_pc_next = fetch_pc + PC_STEP;
  end

  // Queue space is reserved when a request issues: with no request in
  // flight after this edge, a new one may go out only if the queue will
  // still have a free slot for its data. That is what keeps the queue from
  // ever overflowing, and lets a zero-wait memory stream one word per cycle.
  always_comb begin
    req_next  = 1'b0;
    addr_next = mem_addr;
    if (outstanding_next) begin
      req_next  = 1'b1;
      addr_next = mem_addr;
    end else begin
      req_next  = (state_next == ST_RUN) && (count_next < CNT_W'(DEPTH));
      addr_next = fetch_pc_next;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      mem_req  <= req_next;
      mem_addr <= addr_next;
      count    <= count_next;
      if (redirect) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
      end
    end
  end

  // Queue storage carries no reset; entries are only read while counted.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      q_pc[tail]   <= mem_addr;
      q_data[tail] <= mem_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? q_data[head] : '0;
  assign inst_pc    = inst_valid ? q_pc[head]   : '0;
  assign fsm_state  = state;

endmodule
